// File: rtl/dzcpu_ucode_sequencer_if.sv
// Signal bundle between the dzcpu micro-PC sequencer and the fetch path, dispatch LUT, microcode ROM and datapath.
interface dzcpu_ucode_sequencer_if #(
  parameter int UADDR_W = 8,
  parameter int UOP_W   = 14,
  parameter int PAGE_W  = 1,
  parameter int IRQ_N   = 5
);
  // Handshake: mop is consumed on a rising edge only when mop_valid=1 and stall=0 while the
  // sequencer waits for an opcode byte; stall=1 acts as not-ready and freezes every register.
  logic [7:0]         mop;
  logic               mop_valid;
  logic               stall;
  logic               flag_z;
  logic               flag_c;
  logic               ime;
  logic [IRQ_N-1:0]   irq_req;

  logic [7:0]         lut_op;
  logic [PAGE_W-1:0]  lut_page;
  logic [UADDR_W-1:0] lut_idx;

  logic [UADDR_W-1:0] uaddr;
  logic [UOP_W-1:0]   rom_uop;
  logic [UOP_W-1:0]   uop;
  logic               uop_valid;
  logic               pc_inc;
  logic [IRQ_N-1:0]   irq_ack;
  logic               busy;
  logic               fault;

  // Sequencer side.
  modport master (
    input  mop, mop_valid, stall, flag_z, flag_c, ime, irq_req, lut_idx, rom_uop,
    output lut_op, lut_page, uaddr, uop, uop_valid, pc_inc, irq_ack, busy, fault
  );

  // Fetch path, LUT, ROM and datapath side.
  modport slave (
    output mop, mop_valid, stall, flag_z, flag_c, ime, irq_req, lut_idx, rom_uop,
    input  lut_op, lut_page, uaddr, uop, uop_valid, pc_inc, irq_ack, busy, fault
  );
endinterface

// File: rtl/dzcpu_ucode_sequencer.sv
// Micro-PC sequencer: dispatches macro-opcodes through a paged LUT, steps the microcode ROM,
// and resolves end-of-flow, conditional end-of-flow, prefix page jumps and interrupts.
module dzcpu_ucode_sequencer #(
  parameter int UADDR_W    = 8,
  parameter int UOP_W      = 14,
  parameter int PAGE_W     = 1,
  parameter int IRQ_N      = 5,
  parameter int IRQ_BASE   = 200,
  parameter int IRQ_STRIDE = 12
) (
  input  logic                    clk,
  input  logic                    rst,
  dzcpu_ucode_sequencer_if.master bus,
  output logic [1:0]              dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_PAGE = 2'd2
  } state_t;

  localparam logic [3:0] C_OP        = 4'd0;
  localparam logic [3:0] C_INC       = 4'd1;
  localparam logic [3:0] C_EOF       = 4'd2;
  localparam logic [3:0] C_INC_EOF   = 4'd3;
  localparam logic [3:0] C_EOF_Z     = 4'd4;
  localparam logic [3:0] C_EOF_NZ    = 4'd5;
  localparam logic [3:0] C_EOF_C     = 4'd6;
  localparam logic [3:0] C_EOF_NC    = 4'd7;
  localparam logic [3:0] C_JPAGE     = 4'd8;
  localparam logic [3:0] C_INC_JPAGE = 4'd9;

  state_t               state_q, state_d;
  logic [UADDR_W-1:0]   upc_q, upc_d;
  logic [PAGE_W-1:0]    page_q, page_d;
  logic                 fault_q, fault_d;

  logic [3:0]           ctrl;
  logic                 advance;
  logic [7:0]           lut_op;
  logic [PAGE_W-1:0]    lut_page;
  logic                 uop_valid;
  logic                 pc_inc;
  logic [IRQ_N-1:0]     irq_ack;
  logic                 busy;

  int                   irq_k;
  logic                 irq_hit;
  logic [IRQ_N-1:0]     irq_lowest;
  logic [UADDR_W-1:0]   irq_entry;

  // Index 0 wins: scan from the top so the lowest set bit is written last.
  always_comb begin
    irq_k = 0;
    for (int i = IRQ_N - 1; i >= 0; i--) begin
      if (bus.irq_req[i]) irq_k = i;
    end
  end

  assign irq_hit    = |bus.irq_req;
  assign irq_lowest = bus.irq_req & (~bus.irq_req + IRQ_N'(1));
  assign irq_entry  = UADDR_W'(IRQ_BASE + irq_k * IRQ_STRIDE);
  assign ctrl       = bus.rom_uop[UOP_W-1 -: 4];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      upc_q   <= '0;
      page_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      upc_q   <= upc_d;
      page_q  <= page_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    upc_d     = upc_q;
    page_d    = page_q;
    fault_d   = fault_q;
    lut_op    = bus.mop;
    lut_page  = '0;
    uop_valid = 1'b0;
    pc_inc    = 1'b0;
    irq_ack   = '0;
    busy      = 1'b0;
    advance   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.mop_valid && !bus.stall) begin
          state_d = ST_EXEC;
          if (bus.ime && irq_hit) begin
            upc_d   = irq_entry;
            irq_ack = irq_lowest;
          end else begin
            upc_d = bus.lut_idx;
          end
        end
      end

      ST_EXEC: begin
        busy = 1'b1;
        if (!bus.stall) begin
          uop_valid = 1'b1;
          case (ctrl)
            C_OP: advance = 1'b1;
            C_INC: begin
              pc_inc  = 1'b1;
              advance = 1'b1;
            end
            C_EOF: state_d = ST_IDLE;
            C_INC_EOF: begin
              pc_inc  = 1'b1;
              state_d = ST_IDLE;
            end
            C_EOF_Z: begin
              if (bus.flag_z) state_d = ST_IDLE;
              else            advance = 1'b1;
            end
            C_EOF_NZ: begin
              if (!bus.flag_z) state_d = ST_IDLE;
              else             advance = 1'b1;
            end
            C_EOF_C: begin
              if (bus.flag_c) state_d = ST_IDLE;
              else            advance = 1'b1;
            end
            C_EOF_NC: begin
              if (!bus.flag_c) state_d = ST_IDLE;
              else             advance = 1'b1;
            end
            C_JPAGE: begin
              page_d  = bus.rom_uop[PAGE_W-1:0];
              state_d = ST_PAGE;
            end
            C_INC_JPAGE: begin
              pc_inc  = 1'b1;
              page_d  = bus.rom_uop[PAGE_W-1:0];
              state_d = ST_PAGE;
            end
            default: advance = 1'b1;
          endcase

          // Stepping past the last ROM word is a microcode bug: latch it and drop back to IDLE.
          if (advance) begin
            if (upc_q == '1) begin
              fault_d = 1'b1;
              state_d = ST_IDLE;
              upc_d   = '0;
            end else begin
              upc_d = upc_q + UADDR_W'(1);
            end
          end
        end
      end

      ST_PAGE: begin
        busy     = 1'b1;
        lut_page = page_q;
        // Interrupts are deliberately ignored here so the prefix and its opcode stay paired.
        if (bus.mop_valid && !bus.stall) begin
          upc_d   = bus.lut_idx;
          page_d  = '0;
          state_d = ST_EXEC;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.lut_op    = lut_op;
  assign bus.lut_page  = lut_page;
  assign bus.uaddr     = upc_q;
  assign bus.uop       = bus.rom_uop;
  assign bus.uop_valid = uop_valid;
  assign bus.pc_inc    = pc_inc;
  assign bus.irq_ack   = irq_ack;
  assign bus.busy      = busy;
  assign bus.fault     = fault_q;
  assign dbg_state     = state_q;

endmodule
